wash_phase_timer: RTL and testbench
===================================

Name: wash_phase_timer

Overview:
- Timing source for the washing-machine controller: watches the controller's registered `current_state` and produces the one-hot `DoneFlags` the controller consumes.
- On each entry into a timed phase (FillingWater, Washing, Rinsing, Spinning) it loads that phase's duration and counts down. At expiry it pulses the matching done flag for one cycle.
- Sits beside the controller FSM; its `DoneFlags` output drives the FSM's `DoneFlags` input directly.

Parameters:
- CNT_W, 16: counter and Time_Left width.
- FILL_CYCLES, 10: FillingWater duration in clock cycles (must be >= 1 and < 2**CNT_W).
- WASH_CYCLES, 20: Washing duration in cycles, same constraints.
- RINSE_CYCLES, 15: Rinsing duration in cycles, same constraints.
- SPIN_CYCLES, 12: Spinning duration in cycles, same constraints.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-low.
- current_state  in  3  controller phase code: 000 IDLE, 001 FillingWater, 010 Washing, 011 Rinsing, 100 Spinning.
- Pause  in  1  lid-open hold (present only with WASH_TIMER_PAUSE_EN).
- DoneFlags  out  4  one-hot done pulse: 1000 fill, 0100 wash, 0010 rinse, 0001 spin; otherwise 0000.
- Time_Left  out  CNT_W  cycles remaining in the current timed phase.

Behaviour:
- Reset: all registers are registered; reset is sampled only at the CLK edge (RST low at a rising edge). Reset effects:
  - DoneFlags = 0, Time_Left = 0.
  - Internal prev_state = 000, internal FSM = T_IDLE.
- Internal FSM has three states: T_IDLE, T_COUNT, T_DONE.
- Entry detection: a phase entry is `current_state != prev_state`. prev_state updates every cycle.
  - Any entry abandons any count in progress.
  - Re-entry to the same code after leaving it (e.g. Rinsing->Washing->Rinsing on a double wash) is a fresh entry and reloads the duration.
- Timing, with E0 = the edge at which current_state takes timed phase P with duration N:
  - At E1: load Time_Left = N-1 and go to T_COUNT. If N == 1, go straight to T_DONE and assert the flag at E1.
  - Each later edge while in T_COUNT: Time_Left decrements.
  - At edge E_N: Time_Left = 0, DoneFlags = flag(P), FSM enters T_DONE.
  - Net: DoneFlags is high for exactly one cycle, exactly N edges after entry.
- T_DONE:
  - DoneFlags returns to 0 on the next edge and never re-pulses in the same visit, even if current_state does not change.
  - Time_Left holds 0.
  - Leaves only on an entry event.
- Non-timed codes: IDLE and the undefined codes 101, 110 and 111, on entry, send the FSM to T_IDLE. There DoneFlags = 0 and Time_Left = 0.
- Simultaneous entry and expiry: the entry wins. The new phase is loaded and no flag is emitted for the old phase.
- Reset mid-count: the count is abandoned and no flag is emitted. After reset, if current_state is timed (not 000), the first cycle counts as an entry (prev_state = 000).
- At most one DoneFlags bit is ever high, and it is never high in two consecutive cycles.

Optional Feature:
- Macro: WASH_TIMER_PAUSE_EN.
- Defined:
  - The Pause port exists.
  - While Pause = 1 in T_COUNT, Time_Left holds and no flag fires. An expiry that would occur in a paused cycle is deferred until the first unpaused edge.
  - Entry events still load the duration while paused; the count then holds at N-1.
  - Pause has no effect in T_IDLE or T_DONE.
- Undefined: no Pause port, and counting is unconditional.

Decomposition:
- Package wm_pkg holds:
  - State code localparams: IDLE, FillingWater, Washing, Rinsing, Spinning.
  - DoneFlag localparams: Done_FillingWater through Done_Spinning.
  - Timer FSM encodings: T_IDLE, T_COUNT, T_DONE.
- Sub-module wm_down_counter provides load, enable and value, with a zero flag; parameter CNT_W.
- Phase decode, the internal FSM and flag generation stay in the top module.

Test Plan:
- FILL_CYCLES = 4, current_state 000->001 at E0 -> Time_Left 3,2,1,0 at E1..E4; DoneFlags = 1000 only during the cycle after E4; DoneFlags = 0000 after.
- Full sequence 001->010->011->100->000, each advanced the cycle after its flag -> flags 1000, 0100, 0010, 0001 in order, each exactly one cycle, spacing 4/20/15/12 cycles.
- Double wash, 011->010->011: second Rinsing entry reloads to RINSE_CYCLES-1 = 14 -> a second 0010 pulse 15 edges after re-entry.
- RST low for one edge at Time_Left = 7 in Washing -> next cycle DoneFlags = 0, Time_Left = 0; with current_state still 010 -> reload to 19, flag 20 edges later.
- current_state = 110 and held in T_DONE for 50 cycles -> DoneFlags stays 0000 throughout.
- With WASH_TIMER_PAUSE_EN, Pause high for 5 cycles at Time_Left = 2 in Spinning -> Time_Left holds 2; the 0001 pulse arrives 5 cycles later than without Pause.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared codes for the washing-machine controller and its phase timer:
// controller state codes, one-hot done flags and timer FSM states.
package wm_pkg;

    localparam logic [2:0] IDLE         = 3'b000;
    localparam logic [2:0] FillingWater = 3'b001;
    localparam logic [2:0] Washing      = 3'b010;
    localparam logic [2:0] Rinsing      = 3'b011;
    localparam logic [2:0] Spinning     = 3'b100;

    localparam logic [3:0] Done_None         = 4'b0000;
    localparam logic [3:0] Done_FillingWater = 4'b1000;
    localparam logic [3:0] Done_Washing      = 4'b0100;
    localparam logic [3:0] Done_Rinsing      = 4'b0010;
    localparam logic [3:0] Done_Spinning     = 4'b0001;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_DONE  = 2'd2
    } tmr_state_t;

endpackage

// File: rtl/wm_down_counter.sv
// Loadable down counter that stops at zero; load has priority over enable.
module wm_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge CLK) begin
        if (!RST)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (en && value != '0)
            value <= value - 1'b1;
    end

    assign zero = (value == '0);

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer: on each entry into a timed phase, counts its duration and pulses
// the matching one-hot done flag. Optional lid-open hold: WASH_TIMER_PAUSE_EN.
module wash_phase_timer
    import wm_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int FILL_CYCLES  = 10,
    parameter int WASH_CYCLES  = 20,
    parameter int RINSE_CYCLES = 15,
    parameter int SPIN_CYCLES  = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       current_state,
`ifdef WASH_TIMER_PAUSE_EN
    input  logic             Pause,
`endif
    output logic [3:0]       DoneFlags,
    output logic [CNT_W-1:0] Time_Left
);

    logic [2:0]       prev_state;
    tmr_state_t       state;
    logic             entry, timed, run, last, cnt_zero, hold;
    logic [CNT_W-1:0] dur, load_val;
    logic [3:0]       phase_flag;

    always_comb begin
        dur        = '0;
        phase_flag = Done_None;
        timed      = 1'b1;
        case (current_state)
            FillingWater: begin dur = CNT_W'(FILL_CYCLES);  phase_flag = Done_FillingWater; end
            Washing:      begin dur = CNT_W'(WASH_CYCLES);  phase_flag = Done_Washing;      end
            Rinsing:      begin dur = CNT_W'(RINSE_CYCLES); phase_flag = Done_Rinsing;      end
            Spinning:     begin dur = CNT_W'(SPIN_CYCLES);  phase_flag = Done_Spinning;     end
            default:      timed = 1'b0;
        endcase
    end

`ifdef WASH_TIMER_PAUSE_EN
    assign hold = Pause;
`else
    assign hold = 1'b0;
`endif

    assign entry    = (current_state != prev_state);
    assign run      = (state == T_COUNT) && !hold && !cnt_zero;
    assign last     = (Time_Left == CNT_W'(1));
    // Non-timed entries load zero so Time_Left reads 0 in T_IDLE.
    assign load_val = timed ? dur - CNT_W'(1) : '0;

    wm_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (entry),
        .en       (run && !entry),
        .load_val (load_val),
        .value    (Time_Left),
        .zero     (cnt_zero)
    );

    // Entry is checked first so a phase change always beats a pending expiry.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prev_state <= IDLE;
            state      <= T_IDLE;
            DoneFlags  <= Done_None;
        end else begin
            prev_state <= current_state;
            DoneFlags  <= Done_None;
            if (entry) begin
                if (!timed) begin
                    state <= T_IDLE;
                end else if (dur == CNT_W'(1)) begin
                    state     <= T_DONE;
                    DoneFlags <= phase_flag;
                end else begin
                    state <= T_COUNT;
                end
            end else if (run && last) begin
                state     <= T_DONE;
                DoneFlags <= phase_flag;
            end
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Randomized + directed bench for wash_phase_timer against an elapsed-time reference model.
module tb_wash_phase_timer;

    localparam int CNT_W = 16;
    localparam int FILL  = 4;
    localparam int WASH  = 20;
    localparam int RINSE = 15;
    localparam int SPIN  = 12;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [2:0]       current_state = 3'b000;
`ifdef WASH_TIMER_PAUSE_EN
    logic             Pause = 1'b0;
`endif
    logic [3:0]       DoneFlags;
    logic [CNT_W-1:0] Time_Left;

    int total = 0;
    int bad   = 0;

    // reference model: elapsed unpaused edges since the phase was entered
    logic [2:0] m_prev = 3'b000;
    bit         m_timed = 0;
    int         m_dur = 0, m_elapsed = 0, m_tl = 0;
    logic [3:0] m_flags = 4'b0000;
    logic [3:0] last_flags = 4'b0000;

    wash_phase_timer #(
        .CNT_W(CNT_W), .FILL_CYCLES(FILL), .WASH_CYCLES(WASH),
        .RINSE_CYCLES(RINSE), .SPIN_CYCLES(SPIN)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .current_state (current_state),
`ifdef WASH_TIMER_PAUSE_EN
        .Pause         (Pause),
`endif
        .DoneFlags     (DoneFlags),
        .Time_Left     (Time_Left)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dur_of(input logic [2:0] s);
        case (s)
            3'd1: return FILL;
            3'd2: return WASH;
            3'd3: return RINSE;
            3'd4: return SPIN;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] flag_of(input logic [2:0] s);
        case (s)
            3'd1: return 4'b1000;
            3'd2: return 4'b0100;
            3'd3: return 4'b0010;
            3'd4: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit paused();
`ifdef WASH_TIMER_PAUSE_EN
        return Pause;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        bit fired;
        fired   = 0;
        m_flags = 4'b0000;
        if (!RST) begin
            m_prev  = 3'b000;
            m_timed = 0;
            m_tl    = 0;
        end else begin
            if (current_state != m_prev) begin
                m_dur     = dur_of(current_state);
                m_timed   = (m_dur > 0);
                m_elapsed = 0;
                fired     = m_timed && (m_dur == 1);
            end else if (m_timed && !paused() && (m_dur - 1 - m_elapsed) > 0) begin
                m_elapsed++;
                fired = ((m_dur - 1 - m_elapsed) == 0);
            end
            m_tl = m_timed ? (m_dur - 1 - m_elapsed) : 0;
            if (fired) m_flags = flag_of(current_state);
            m_prev = current_state;
        end
    endtask

    // One clock: update the model at the edge, then compare just after it.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("model_tl", 32'(Time_Left), 32'(m_tl));
        chk("model_flags", 32'(DoneFlags), 32'(m_flags));
        chk("flag_onehot", 32'($countones(DoneFlags) <= 1), 32'd1);
        chk("flag_consec", 32'((last_flags != 0) && (DoneFlags != 0)), 32'd0);
        last_flags = DoneFlags;
    endtask

    task automatic wait_flag(input string tag, input logic [3:0] exp_flag, input int exp_edges);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (DoneFlags == 4'b0000 && n < exp_edges + 5);
        chk({tag, "_flag"}, 32'(DoneFlags), 32'(exp_flag));
        chk({tag, "_edges"}, n, exp_edges);
    endtask

    task automatic run_to_tl(input string tag, input int tl);
        int n;
        n = 0;
        while (32'(Time_Left) != tl && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_reach"}, 32'(Time_Left), tl);
    endtask

    initial begin
        int fill_exp[4];
        fill_exp = '{3, 2, 1, 0};

        // reset
        RST = 1'b0;
        step(); step();
        chk("rst_flags", 32'(DoneFlags), 0);
        chk("rst_tl", 32'(Time_Left), 0);
        RST = 1'b1;
        step();

        // fill countdown, explicit values
        current_state = 3'b001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_tl", 32'(Time_Left), fill_exp[i]);
            chk("fill_flag", 32'(DoneFlags), (i == 3) ? 32'h8 : 32'h0);
        end
        step();
        chk("fill_after", 32'(DoneFlags), 0);
        chk("fill_after_tl", 32'(Time_Left), 0);

        // full cycle, each phase advanced as its flag shows
        current_state = 3'b000; step();
        current_state = 3'b001; wait_flag("seq_fill", 4'b1000, FILL);
        current_state = 3'b010; wait_flag("seq_wash", 4'b0100, WASH);
        current_state = 3'b011; wait_flag("seq_rinse", 4'b0010, RINSE);
        current_state = 3'b100; wait_flag("seq_spin", 4'b0001, SPIN);
        current_state = 3'b000; step();

        // double wash: rinse re-entry reloads
        current_state = 3'b011; step();
        current_state = 3'b010; step();
        current_state = 3'b011; step();
        chk("dw_reload", 32'(Time_Left), RINSE - 1);
        wait_flag("dw_rinse", 4'b0010, RINSE - 1);

        // hold in T_DONE: no re-pulse
        for (int i = 0; i < 50; i++) begin
            step();
            chk("done_hold", 32'(DoneFlags), 0);
        end

        // reset mid-wash
        current_state = 3'b010; step();
        run_to_tl("rst_mid", 7);
        RST = 1'b0; step();
        chk("rst_mid_flags", 32'(DoneFlags), 0);
        chk("rst_mid_tl", 32'(Time_Left), 0);
        RST = 1'b1; step();
        chk("rst_reload", 32'(Time_Left), WASH - 1);
        wait_flag("rst_wash", 4'b0100, WASH - 1);

        // undefined code
        current_state = 3'b110;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("undef_flags", 32'(DoneFlags), 0);
        end
        chk("undef_tl", 32'(Time_Left), 0);

`ifdef WASH_TIMER_PAUSE_EN
        // pause in spinning at Time_Left = 2
        current_state = 3'b100; step();
        run_to_tl("pause", 2);
        Pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pause_hold", 32'(Time_Left), 2);
        end
        Pause = 1'b0;
        wait_flag("pause_spin", 4'b0001, 2);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0)
                current_state = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 39) == 0)
                current_state = 3'($urandom_range(1, 4));
`ifdef WASH_TIMER_PAUSE_EN
            Pause = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
